// File: rtl/serial_bus_arbiter_if.sv
// Bus-ownership handshake between the requesting masters and the serial bus arbiter.
// Modport master is the arbiter side (drives grants); modport slave is the requester side.
interface serial_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_WIDTH   = 1
);
    logic [NUM_MASTERS-1:0] mbreq;
    logic [NUM_MASTERS-1:0] mbgrant;
    logic [SEL_WIDTH-1:0]   msel;
    logic                   bbusy;
    logic                   berr;

    modport master (input mbreq, output mbgrant, msel, bbusy, berr);
    modport slave  (output mbreq, input mbgrant, msel, bbusy, berr);
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin owner arbiter for the shared serial bus, with a dead cycle between
// tenures and a tenure-timeout watchdog. All outputs are registered.
module serial_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_WIDTH   = 1,
    parameter int TIMEOUT     = 1024
) (
    input logic                  clk,
    input logic                  rst,
    serial_bus_arbiter_if.master bus
);
    // state | meaning
    // IDLE  | no owner, arbitrate every cycle
    // GRANT | one owner holds the bus, watchdog running
    // TURN  | dead cycle after a tenure, arbitrate the next owner
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [15:0]          HOLD_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic [SEL_WIDTH-1:0] LAST_RST  = SEL_WIDTH'(NUM_MASTERS - 1);

    state_t                 state, state_nxt;
    logic [SEL_WIDTH-1:0]   last, last_nxt, msel_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [15:0]            hold_cnt, hold_cnt_nxt;
    logic                   berr_nxt;
    logic                   win_valid;
    logic [SEL_WIDTH-1:0]   win;
    logic                   owner_req;
    logic                   timeout_hit;
    int                     cand;

    // Search starts just after the previous winner, so the last owner ranks lowest.
    always_comb begin
        win_valid = 1'b0;
        win       = last;
        cand      = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(last) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!win_valid && bus.mbreq[SEL_WIDTH'(cand)]) begin
                win_valid = 1'b1;
                win       = SEL_WIDTH'(cand);
            end
        end
    end

    assign owner_req   = bus.mbreq[bus.msel];
    assign timeout_hit = (TIMEOUT != 0) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= LAST_RST;
            hold_cnt    <= 16'd0;
            bus.mbgrant <= '0;
            bus.msel    <= '0;
            bus.bbusy   <= 1'b0;
            bus.berr    <= 1'b0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            hold_cnt    <= hold_cnt_nxt;
            bus.mbgrant <= grant_nxt;
            bus.msel    <= msel_nxt;
            bus.bbusy   <= |grant_nxt;
            bus.berr    <= berr_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, TURN: state_nxt = win_valid ? GRANT : IDLE;
            GRANT:      state_nxt = (!owner_req || timeout_hit) ? TURN : GRANT;
            default:    state_nxt = IDLE;
        endcase
    end

    // Release wins over a coincident timeout, so berr only fires while the owner still requests.
    always_comb begin
        grant_nxt    = '0;
        msel_nxt     = bus.msel;
        last_nxt     = last;
        berr_nxt     = 1'b0;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE, TURN: begin
                if (win_valid) begin
                    grant_nxt[win] = 1'b1;
                    msel_nxt       = win;
                    last_nxt       = win;
                    hold_cnt_nxt   = 16'd0;
                end
            end
            GRANT: begin
                if (owner_req && !timeout_hit) begin
                    grant_nxt    = bus.mbgrant;
                    hold_cnt_nxt = hold_cnt + 16'd1;
                end else if (owner_req) begin
                    berr_nxt = 1'b1;
                end
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
    end
endmodule
